tanimoto_cmp_array: RTL and testbench



---
 rtl/tanimoto_pkg.sv | 33 +++
 rtl/tanimoto_thr_table.sv | 62 ++++++
 rtl/tanimoto_cmp_array.sv | 181 ++++++++++++++++++
 tb/tb_tanimoto_cmp_array.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tanimoto_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tanimoto_pkg
// Description : Shared constants and width helpers for the Tanimoto
//               threshold comparator array and its threshold table.
// Revision    : 1.0 - initial multi-lane release
// ============================================================================
package tanimoto_pkg;

    // Compare mode encodings, applied to a whole beat
    localparam logic MODE_INCL   = 1'b0;
    localparam logic MODE_STRICT = 1'b1;

    // No-hit threshold: all-ones, truncated to the table word width by users
    localparam logic [31:0] THR_NONE = '1;

    // Bits needed to hold a popcount in 0..vector_width
    function automatic int cnt_width(input int vector_width);
        return $clog2(vector_width + 1);
    endfunction

    // One extra bit so |A|+|B| never overflows
    function automatic int sum_width(input int vector_width);
        return cnt_width(vector_width) + 1;
    endfunction

    // One table entry per possible sum 0..2*vector_width
    function automatic int depth(input int vector_width);
        return 2 * vector_width + 1;
    endfunction

endpackage : tanimoto_pkg
`default_nettype wire

// File: rtl/tanimoto_thr_table.sv
`default_nettype none
// ============================================================================
// Module      : tanimoto_thr_table
// Description : Threshold table indexed by |A|+|B|. One write port, LANES
//               registered read ports, synchronous reset to all-ones.
// Revision    : 1.0 - initial multi-lane release
// ============================================================================
module tanimoto_thr_table
    import tanimoto_pkg::*;
#(
    parameter int VECTOR_WIDTH = 35,
    parameter int LANES        = 4,
    parameter int SUM_WIDTH    = sum_width(VECTOR_WIDTH),
    parameter int DEPTH        = depth(VECTOR_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [SUM_WIDTH-1:0]       i_wr_addr,
    input  logic [SUM_WIDTH-1:0]       i_wr_data,
    input  logic [LANES*SUM_WIDTH-1:0] i_rd_addr,
    output logic [LANES*SUM_WIDTH-1:0] o_rd_data
);

    localparam logic [SUM_WIDTH-1:0] c_thr_none = THR_NONE[SUM_WIDTH-1:0];
    localparam logic [SUM_WIDTH-1:0] c_depth    = SUM_WIDTH'(DEPTH);

    logic [SUM_WIDTH-1:0] r_mem [DEPTH];

    // Table storage: reset to no-hit, out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= c_thr_none;
            end
        end else if (i_wr_en && (i_wr_addr < c_depth)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_rd_port
        logic [SUM_WIDTH-1:0] w_addr;
        logic [SUM_WIDTH-1:0] r_data;

        assign w_addr = i_rd_addr[k*SUM_WIDTH +: SUM_WIDTH];

        // Registered read; sums past the table (only from bad inputs) read as no-hit
        always_ff @(posedge clk) begin
            if (rst) begin
                r_data <= c_thr_none;
            end else if (w_addr < c_depth) begin
                r_data <= r_mem[w_addr];
            end else begin
                r_data <= c_thr_none;
            end
        end

        assign o_rd_data[k*SUM_WIDTH +: SUM_WIDTH] = r_data;
    end

endmodule : tanimoto_thr_table
`default_nettype wire

// File: rtl/tanimoto_cmp_array.sv
`default_nettype none
// ============================================================================
// Module      : tanimoto_cmp_array
// Description : LANES-wide Tanimoto threshold comparator. Three-stage lane
//               pipeline (sum/check, table lookup, compare) with a shared
//               threshold table, sticky range-error flag and a saturating
//               hit counter.
// Revision    : 1.0 - initial multi-lane release
// ============================================================================
module tanimoto_cmp_array
    import tanimoto_pkg::*;
#(
    parameter int  VECTOR_WIDTH  = 35,
    parameter int  LANES         = 4,
    parameter int  TAG_WIDTH     = 16,
    parameter int  HIT_CNT_WIDTH = 32,
    localparam int CNT_WIDTH     = cnt_width(VECTOR_WIDTH),
    localparam int SUM_WIDTH     = sum_width(VECTOR_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES*CNT_WIDTH-1:0] i_CntA,
    input  logic [LANES*CNT_WIDTH-1:0] i_CntB,
    input  logic [LANES*CNT_WIDTH-1:0] i_CntC,
    input  logic [LANES-1:0]           i_Valid,
    input  logic                       i_Mode,
    input  logic [TAG_WIDTH-1:0]       i_Tag,
    input  logic                       i_TblWrEn,
    input  logic [SUM_WIDTH-1:0]       i_TblAddr,
    input  logic [SUM_WIDTH-1:0]       i_TblDin,
    input  logic                       i_CntClr,
    output logic [LANES-1:0]           o_Valid,
    output logic [LANES-1:0]           o_Hit,
    output logic [TAG_WIDTH-1:0]       o_Tag,
    output logic                       o_Err,
    output logic [HIT_CNT_WIDTH-1:0]   o_HitCnt
);

    localparam int                   c_pop_w = $clog2(LANES + 1);
    localparam logic [CNT_WIDTH-1:0] c_vmax  = CNT_WIDTH'(VECTOR_WIDTH);

    // Stage 0 (combinational from inputs)
    logic [CNT_WIDTH-1:0] w_a   [LANES];
    logic [CNT_WIDTH-1:0] w_b   [LANES];
    logic [CNT_WIDTH-1:0] w_c   [LANES];
    logic [SUM_WIDTH-1:0] w_sum [LANES];
    logic [LANES-1:0]     w_bad;

    // Stage 1 registers
    logic [LANES-1:0]     r_s1_valid;
    logic [LANES-1:0]     r_s1_bad;
    logic [SUM_WIDTH-1:0] r_s1_sum [LANES];
    logic [CNT_WIDTH-1:0] r_s1_c   [LANES];
    logic                 r_s1_mode;
    logic [TAG_WIDTH-1:0] r_s1_tag;

    // Stage 2 registers (threshold arrives from the table's read register)
    logic [LANES-1:0]       r_s2_valid;
    logic [LANES-1:0]       r_s2_bad;
    logic [CNT_WIDTH-1:0]   r_s2_c [LANES];
    logic                   r_s2_mode;
    logic [TAG_WIDTH-1:0]   r_s2_tag;
    logic [LANES*SUM_WIDTH-1:0] w_rd_addr;
    logic [LANES*SUM_WIDTH-1:0] w_thr_bus;

    // Stage 3 / outputs
    logic [LANES-1:0]         w_hit;
    logic [LANES-1:0]         r_out_valid;
    logic [LANES-1:0]         r_out_hit;
    logic [TAG_WIDTH-1:0]     r_out_tag;
    logic                     r_err;
    logic [HIT_CNT_WIDTH-1:0] r_hit_cnt;
    logic [c_pop_w-1:0]       w_hit_pop;
    logic [HIT_CNT_WIDTH:0]   w_cnt_sum;

    for (genvar k = 0; k < LANES; k++) begin : g_lane_in
        assign w_a[k]   = i_CntA[k*CNT_WIDTH +: CNT_WIDTH];
        assign w_b[k]   = i_CntB[k*CNT_WIDTH +: CNT_WIDTH];
        assign w_c[k]   = i_CntC[k*CNT_WIDTH +: CNT_WIDTH];
        assign w_sum[k] = {1'b0, w_a[k]} + {1'b0, w_b[k]};
        // Counts that cannot come from a real fingerprint pair
        assign w_bad[k] = (w_a[k] > c_vmax) || (w_b[k] > c_vmax) ||
                          (w_c[k] > w_a[k]) || (w_c[k] > w_b[k]);
        assign w_rd_addr[k*SUM_WIDTH +: SUM_WIDTH] = r_s1_sum[k];
    end

    // Control pipeline: only valids, hits and the output tag reset, so rst flushes beats
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= '0;
            r_s2_valid  <= '0;
            r_out_valid <= '0;
            r_out_hit   <= '0;
            r_out_tag   <= '0;
        end else begin
            r_s1_valid  <= i_Valid;
            r_s2_valid  <= r_s1_valid;
            r_out_valid <= r_s2_valid;
            r_out_hit   <= w_hit;
            r_out_tag   <= r_s2_tag;
        end
    end

    // Datapath stage registers; contents are don't-care while the lane is invalid
    always_ff @(posedge clk) begin
        r_s1_bad  <= w_bad;
        r_s1_mode <= i_Mode;
        r_s1_tag  <= i_Tag;
        r_s2_bad  <= r_s1_bad;
        r_s2_mode <= r_s1_mode;
        r_s2_tag  <= r_s1_tag;
        for (int k = 0; k < LANES; k++) begin
            r_s1_sum[k] <= w_sum[k];
            r_s1_c[k]   <= w_c[k];
            r_s2_c[k]   <= r_s1_c[k];
        end
    end

    tanimoto_thr_table #(
        .VECTOR_WIDTH (VECTOR_WIDTH),
        .LANES        (LANES),
        .SUM_WIDTH    (SUM_WIDTH),
        .DEPTH        (depth(VECTOR_WIDTH))
    ) u_thr_table (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (i_TblWrEn),
        .i_wr_addr (i_TblAddr),
        .i_wr_data (i_TblDin),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_thr_bus)
    );

    for (genvar k = 0; k < LANES; k++) begin : g_lane_cmp
        logic [SUM_WIDTH-1:0] w_thr;
        logic [SUM_WIDTH-1:0] w_c_ext;

        assign w_thr    = w_thr_bus[k*SUM_WIDTH +: SUM_WIDTH];
        assign w_c_ext  = {1'b0, r_s2_c[k]};
        assign w_hit[k] = r_s2_valid[k] & ~r_s2_bad[k] &
                          ((r_s2_mode == MODE_STRICT) ? (w_c_ext > w_thr)
                                                      : (w_c_ext >= w_thr));
    end

    // Sticky range error, raised alongside the offending beat's outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (|(r_s2_valid & r_s2_bad)) begin
            r_err <= 1'b1;
        end
    end

    // Number of hits on the current output beat
    always_comb begin
        w_hit_pop = '0;
        for (int k = 0; k < LANES; k++) begin
            w_hit_pop = w_hit_pop + c_pop_w'(r_out_hit[k]);
        end
        w_cnt_sum = {1'b0, r_hit_cnt} + (HIT_CNT_WIDTH + 1)'(w_hit_pop);
    end

    // Saturating hit counter; a clear discards the hits of its own cycle
    always_ff @(posedge clk) begin
        if (rst || i_CntClr) begin
            r_hit_cnt <= '0;
        end else if (w_cnt_sum[HIT_CNT_WIDTH]) begin
            r_hit_cnt <= '1;
        end else begin
            r_hit_cnt <= w_cnt_sum[HIT_CNT_WIDTH-1:0];
        end
    end

    assign o_Valid  = r_out_valid;
    assign o_Hit    = r_out_hit;
    assign o_Tag    = r_out_tag;
    assign o_Err    = r_err;
    assign o_HitCnt = r_hit_cnt;

endmodule : tanimoto_cmp_array
`default_nettype wire

// File: tb/tb_tanimoto_cmp_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_tanimoto_cmp_array
// Description : Directed self-checking bench for tanimoto_cmp_array
//               (VECTOR_WIDTH=35, LANES=4, 4-bit hit counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tanimoto_cmp_array;

    localparam int VW  = 35;
    localparam int LN  = 4;
    localparam int TW  = 16;
    localparam int HCW = 4;
    localparam int CW  = 6;
    localparam int SW  = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic [LN*CW-1:0] cnt_a, cnt_b, cnt_c;
    logic [LN-1:0]   valid;
    logic            mode;
    logic [TW-1:0]   tag;
    logic            tbl_wr_en;
    logic [SW-1:0]   tbl_addr, tbl_din;
    logic            cnt_clr;
    logic [LN-1:0]   o_valid, o_hit;
    logic [TW-1:0]   o_tag;
    logic            o_err;
    logic [HCW-1:0]  o_hit_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    tanimoto_cmp_array #(
        .VECTOR_WIDTH  (VW),
        .LANES         (LN),
        .TAG_WIDTH     (TW),
        .HIT_CNT_WIDTH (HCW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_CntA    (cnt_a),
        .i_CntB    (cnt_b),
        .i_CntC    (cnt_c),
        .i_Valid   (valid),
        .i_Mode    (mode),
        .i_Tag     (tag),
        .i_TblWrEn (tbl_wr_en),
        .i_TblAddr (tbl_addr),
        .i_TblDin  (tbl_din),
        .i_CntClr  (cnt_clr),
        .o_Valid   (o_valid),
        .o_Hit     (o_hit),
        .o_Tag     (o_tag),
        .o_Err     (o_err),
        .o_HitCnt  (o_hit_cnt)
    );

    always #5 clk = ~clk;

    // One clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", name, obs, exp);
        end
    endtask

    task automatic set_lane(input int k, input int a, input int b, input int c, input logic v);
        cnt_a[k*CW +: CW] = CW'(a);
        cnt_b[k*CW +: CW] = CW'(b);
        cnt_c[k*CW +: CW] = CW'(c);
        valid[k]          = v;
    endtask

    task automatic clear_beat();
        cnt_a = '0;
        cnt_b = '0;
        cnt_c = '0;
        valid = '0;
        mode  = 1'b0;
        tag   = '0;
    endtask

    initial begin
        rst = 1'b1; clear_beat(); tbl_wr_en = 1'b0; tbl_addr = '0; tbl_din = '0; cnt_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_valid", 32'(o_valid), 32'h0);
        check("rst_hit",   32'(o_hit),   32'h0);
        check("rst_tag",   32'(o_tag),   32'h0);
        check("rst_err",   32'(o_err),   32'h0);
        check("rst_cnt",   32'(o_hit_cnt), 32'h0);

        // Unprogrammed table: nothing hits
        set_lane(0, 3, 4, 3, 1'b1); set_lane(1, 0, 0, 0, 1'b1); set_lane(2, 35, 35, 35, 1'b1);
        tag = 16'h1234;
        tick(); clear_beat(); tick(); tick();
        check("unprog_valid", 32'(o_valid), 32'h7);
        check("unprog_hit",   32'(o_hit),   32'h0);
        check("unprog_tag",   32'(o_tag),   32'h1234);

        // Program table[s] = floor(s/2)
        for (int s = 0; s <= 2 * VW; s++) begin
            tbl_wr_en = 1'b1; tbl_addr = SW'(s); tbl_din = SW'(s / 2);
            tick();
        end
        tbl_wr_en = 1'b0;

        // Basic inclusive hit/miss with tag, plus latency
        set_lane(0, 3, 4, 3, 1'b1); set_lane(1, 6, 8, 6, 1'b1); tag = 16'hABCD;
        tick(); clear_beat(); tick();
        check("basic_early_valid", 32'(o_valid), 32'h0);
        tick();
        check("basic_valid", 32'(o_valid), 32'h3);
        check("basic_hit",   32'(o_hit),   32'h1);
        check("basic_tag",   32'(o_tag),   32'hABCD);

        // Strict beat then inclusive beat back-to-back (equality boundary)
        mode = 1'b1; tag = 16'h0A0A;
        set_lane(0, 3, 4, 3, 1'b1); set_lane(1, 35, 35, 35, 1'b1);
        set_lane(2, 10, 10, 10, 1'b1); set_lane(3, 4, 5, 4, 1'b1);
        tick();
        mode = 1'b0; tag = 16'h0B0B;
        set_lane(0, 35, 35, 35, 1'b1); set_lane(1, 35, 35, 34, 1'b1);
        set_lane(2, 10, 10, 10, 1'b1); set_lane(3, 10, 10, 10, 1'b0);
        tick(); clear_beat(); tick();
        check("strict_valid", 32'(o_valid), 32'hF);
        check("strict_hit",   32'(o_hit),   32'h0);
        check("strict_tag",   32'(o_tag),   32'h0A0A);
        tick();
        check("incl_valid", 32'(o_valid), 32'h7);
        check("incl_hit",   32'(o_hit),   32'h5);
        check("incl_tag",   32'(o_tag),   32'h0B0B);

        // A bad lane that is not valid must not raise the error
        set_lane(0, 3, 4, 5, 1'b0); set_lane(1, 2, 2, 1, 1'b1);
        tick(); clear_beat(); tick(); tick();
        check("inv_bad_err",   32'(o_err),   32'h0);
        check("inv_bad_valid", 32'(o_valid), 32'h2);
        check("inv_bad_hit",   32'(o_hit),   32'h0);

        // Range errors (c>a, c>b) suppress hits and set the sticky flag at t+3
        set_lane(0, 3, 4, 5, 1'b1); set_lane(1, 5, 3, 4, 1'b1); set_lane(2, 10, 10, 10, 1'b1);
        tick(); clear_beat(); tick();
        check("err_before", 32'(o_err), 32'h0);
        tick();
        check("err_set",   32'(o_err),   32'h1);
        check("err_hit",   32'(o_hit),   32'h4);
        check("err_valid", 32'(o_valid), 32'h7);
        set_lane(0, 10, 10, 10, 1'b1);
        tick(); clear_beat(); tick(); tick();
        check("err_sticky",     32'(o_err), 32'h1);
        check("err_after_hit",  32'(o_hit), 32'h1);

        // Write/read ordering on table[7]
        tbl_wr_en = 1'b1; tbl_addr = 7'd7; tbl_din = 7'd7;
        set_lane(0, 3, 4, 3, 1'b1); tag = 16'h0001;
        tick();
        tbl_din = 7'd0; tag = 16'h0002;
        tick();
        tbl_wr_en = 1'b0; clear_beat();
        tick();
        check("wr_same_cycle_hit", 32'(o_hit), 32'h0);
        check("wr_same_cycle_tag", 32'(o_tag), 32'h0001);
        tick();
        check("wr_next_cycle_hit", 32'(o_hit), 32'h1);

        // Strict mode that can hit (table[7]=0)
        mode = 1'b1; set_lane(0, 3, 4, 3, 1'b1); set_lane(1, 3, 4, 0, 1'b1);
        tick(); clear_beat(); tick(); tick();
        check("strict_thr0_hit", 32'(o_hit), 32'h1);

        // Counter saturation: 5 beats of 4 hits each in a 4-bit counter
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < LN; k++) set_lane(k, 10, 10, 10, 1'b1);
            tick();
        end
        clear_beat();
        check("cnt_partial", 32'(o_hit_cnt), 32'd8);
        tick(); tick(); tick(); tick();
        check("cnt_saturated", 32'(o_hit_cnt), 32'd15);

        // Clear in a hitting cycle wins
        for (int k = 0; k < LN; k++) set_lane(k, 10, 10, 10, 1'b1);
        tick(); clear_beat(); tick(); tick();
        check("clr_cycle_hit", 32'(o_hit), 32'hF);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_cnt", 32'(o_hit_cnt), 32'd0);
        tick();
        check("clr_cnt_hold", 32'(o_hit_cnt), 32'd0);

        // Reset with three beats in flight (the last one during reset)
        for (int k = 0; k < LN; k++) set_lane(k, 10, 10, 10, 1'b1);
        tag = 16'h1111;
        tick();
        tag = 16'h2222;
        tick();
        tag = 16'h3333; rst = 1'b1;
        tick();
        rst = 1'b0; clear_beat();
        for (int i = 0; i < 4; i++) begin
            check("rst_flush_valid", 32'(o_valid), 32'h0);
            tick();
        end
        check("rst_flush_hit", 32'(o_hit),     32'h0);
        check("rst_flush_tag", 32'(o_tag),     32'h0);
        check("rst_flush_err", 32'(o_err),     32'h0);
        check("rst_flush_cnt", 32'(o_hit_cnt), 32'h0);

        // Table is back to all-ones (s=0 would have hit with threshold 0)
        set_lane(0, 0, 0, 0, 1'b1); set_lane(1, 10, 10, 10, 1'b1);
        tick(); clear_beat(); tick(); tick();
        check("rst_tbl_valid", 32'(o_valid), 32'h3);
        check("rst_tbl_hit",   32'(o_hit),   32'h0);

        // Count above VECTOR_WIDTH is a range error
        set_lane(0, 36, 0, 0, 1'b1);
        tick(); clear_beat(); tick();
        check("range_a_before", 32'(o_err), 32'h0);
        tick();
        check("range_a_err", 32'(o_err), 32'h1);
        check("range_a_hit", 32'(o_hit), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_tanimoto_cmp_array
`default_nettype wire
